lc_mem_responder: RTL

- Synthesizable lower-level responder for the L1D's lower-cache (LC) port. It sits where the L2/memory would be and serves as the far end of the L1D LC handshake.
- Accepts line reads (fills) and line writes (writebacks) from the L1D, queues them in order, and backs them with a line-granular memory array.
- Returns read data after a fixed programmable latency. Used as an FPGA/sim backing store and as the LC peer in L1D integration benches.

---
 rtl/lc_pkg.sv | 32 +++
 rtl/lc_req_fifo.sv | 50 +++++
 rtl/lc_mem_responder.sv | 124 ++++++++++++
 3 files changed

// File: rtl/lc_pkg.sv
// Shared types and helpers for the lower-cache (LC) responder.
//   PADDR_BITS : physical address width, matches the L1D
//   B          : line size in bytes
//   LINE_BITS  : line width in bits
//   OFF_BITS   : byte-offset bits within a line
//   lc_req_t   : one queued L1D request (address, line data, write flag)
//   lc_rsp_state_e : responder FSM states
//   line_align : clears the byte-offset bits of an address
package lc_pkg;

  localparam int unsigned PADDR_BITS = 22;
  localparam int unsigned B          = 64;
  localparam int unsigned LINE_BITS  = 8 * B;
  localparam int unsigned OFF_BITS   = $clog2(B);

  typedef struct packed {
    logic [PADDR_BITS-1:0] addr;
    logic [LINE_BITS-1:0]  data;
    logic                  we;
  } lc_req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lc_rsp_state_e;

  function automatic logic [PADDR_BITS-1:0] line_align(input logic [PADDR_BITS-1:0] addr);
    return {addr[PADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
  endfunction

endpackage

// File: rtl/lc_req_fifo.sv
// In-order request queue of lc_req_t entries.
//   i_clk, i_rst_n : clock, asynchronous active-low reset (empties the queue)
//   i_push, i_req  : enqueue i_req; ignored while full
//   i_pop          : drop the head entry; ignored while empty
//   o_head         : current head entry (valid when !o_empty)
//   o_full, o_empty: occupancy flags
module lc_req_fifo
  import lc_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_push,
  input  lc_req_t i_req,
  input  logic    i_pop,
  output lc_req_t o_head,
  output logic    o_full,
  output logic    o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty on wrap-around.
  logic [AW:0] r_wr_ptr, r_rd_ptr;
  lc_req_t     r_mem [DEPTH];
  logic        w_push, w_pop;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; only the pointers define what is live.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_req;
  end

endmodule

// File: rtl/lc_mem_responder.sv
// Far end of the L1D lower-cache port: queues line reads/writes in order, backs them with a
// line-granular array and returns read data after LATENCY extra cycles.
//   clk_in, rst_N_in            : clock, asynchronous active-low reset
//   l1_valid_in/l1_ready_out    : request handshake (ready = queue not full)
//   l1_addr_in/l1_value_in/l1_we_in : request address, writeback line, 1=write
//   l1_valid_out/l1_ready_in    : fill response handshake
//   l1_addr_out/l1_value_out    : line-aligned fill address and data
module lc_mem_responder
  import lc_pkg::*;
#(
  parameter int unsigned MEM_LINES = 64,
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned LATENCY   = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_N_in,
  input  logic                  l1_valid_in,
  output logic                  l1_ready_out,
  input  logic [PADDR_BITS-1:0] l1_addr_in,
  input  logic [LINE_BITS-1:0]  l1_value_in,
  input  logic                  l1_we_in,
  output logic                  l1_valid_out,
  input  logic                  l1_ready_in,
  output logic [PADDR_BITS-1:0] l1_addr_out,
  output logic [LINE_BITS-1:0]  l1_value_out
);

  localparam int unsigned IDX_BITS = $clog2(MEM_LINES);

  logic                  w_full, w_empty, w_push, w_pop;
  lc_req_t               w_req, w_head;
  logic [IDX_BITS-1:0]   w_idx;

  logic [LINE_BITS-1:0]  r_mem [MEM_LINES];
  logic [MEM_LINES-1:0]  r_line_valid;
  lc_rsp_state_e         r_state;
  logic [7:0]            r_cnt;
  logic                  r_valid_out;
  logic [PADDR_BITS-1:0] r_rsp_addr;
  logic [LINE_BITS-1:0]  r_rsp_data;

  // Gated by reset so the L1D sees no ready while the responder is held in reset.
  assign l1_ready_out = rst_N_in & ~w_full;
  assign w_push       = l1_valid_in & l1_ready_out;
  assign w_req        = '{addr: l1_addr_in, data: l1_value_in, we: l1_we_in};
  assign w_pop        = (r_state == IDLE) & ~w_empty;
  // Upper address bits are dropped, so addresses alias modulo MEM_LINES*B.
  assign w_idx        = w_head.addr[OFF_BITS +: IDX_BITS];

  assign l1_valid_out = r_valid_out;
  assign l1_addr_out  = r_rsp_addr;
  assign l1_value_out = r_rsp_data;

  lc_req_fifo #(
    .DEPTH (REQ_DEPTH)
  ) u_req_fifo (
    .i_clk   (clk_in),
    .i_rst_n (rst_N_in),
    .i_push  (w_push),
    .i_req   (w_req),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Array contents survive reset; per-line valid bits make stale data read as zero.
  always_ff @(posedge clk_in) begin
    if (w_pop && w_head.we) r_mem[w_idx] <= w_head.data;
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_line_valid <= '0;
    end else if (w_pop && w_head.we) begin
      r_line_valid[w_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_valid_out <= 1'b0;
      r_rsp_addr  <= '0;
      r_rsp_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop && !w_head.we) begin
            // Sampled at pop: older queued writes are visible, younger ones are not.
            r_rsp_data <= r_line_valid[w_idx] ? r_mem[w_idx] : '0;
            r_rsp_addr <= line_align(w_head.addr);
            r_cnt      <= 8'(LATENCY);
            if (LATENCY == 0) begin
              r_state     <= RESP;
              r_valid_out <= 1'b1;
            end else begin
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 8'd1;
          if (r_cnt == 8'd1) begin
            r_state     <= RESP;
            r_valid_out <= 1'b1;
          end
        end
        RESP: begin
          if (l1_ready_in) begin
            r_state     <= IDLE;
            r_valid_out <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_valid_out <= 1'b0;
        end
      endcase
    end
  end

endmodule
